// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared types, register map and helpers for the board-to-board ball link
package link_pkg;

   // Transmit sequencer states
   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      DONE
   } tx_state_t;

   // Opponent slave register map; frame byte N+1 carries register N
   localparam int REG_Y0    = 0;
   localparam int REG_Y1    = 1;
   localparam int REG_VY    = 2;
   localparam int REG_GRAV  = 3;
   localparam int REG_SPEED = 4;
   localparam int REG_WIN   = 5;

   // Register pointer byte plus six data registers
   localparam int FRAME_BYTES = 7;

   // Ball state captured at the start of a frame
   typedef struct packed {
      logic [9:0] y;
      logic [9:0] vy;
      logic [1:0] grav;
      logic       slow;
      logic       lose;
   } snap_t;

   // Clamp a 10-bit signed velocity into the 8-bit signed register range
   function automatic logic [7:0] sat10to8(input logic signed [9:0] v);
      if (v > 10'sd127) begin
         return 8'h7F;
      end else if (v < -10'sd128) begin
         return 8'h80;
      end else begin
         return v[7:0];
      end
   endfunction

endpackage

// File: rtl/ball_packet_tx_if.sv
// rtl/ball_packet_tx_if.sv - byte-level handshake between frame sender and I2C master
interface ball_packet_tx_if;
   logic [6:0] i2c_addr;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_first;
   logic       tx_last;
   logic       tx_ready;
   logic       tx_nack;

   modport master (
      output i2c_addr,
      output tx_valid,
      output tx_data,
      output tx_first,
      output tx_last,
      input  tx_ready,
      input  tx_nack
   );

   modport slave (
      input  i2c_addr,
      input  tx_valid,
      input  tx_data,
      input  tx_first,
      input  tx_last,
      output tx_ready,
      output tx_nack
   );
endinterface

// File: rtl/frame_builder.sv
// rtl/frame_builder.sv - combinational frame byte mux from the latched ball snapshot
module frame_builder
   import link_pkg::*;
(
   input  snap_t      snap,
   input  logic [2:0] idx,
   output logic [7:0] byte_out
);

   // Select frame byte idx; byte 0 is the starting register pointer
   always_comb begin
      byte_out = 8'h00;
      case (idx)
         3'd0:              byte_out = 8'(REG_Y0);
         3'(REG_Y0 + 1):    byte_out = {snap.y[9:8], 6'b0};
         3'(REG_Y1 + 1):    byte_out = snap.y[7:0];
         3'(REG_VY + 1):    byte_out = sat10to8($signed(snap.vy));
         3'(REG_GRAV + 1):  byte_out = {6'b0, snap.grav};
         3'(REG_SPEED + 1): byte_out = {7'b0, snap.slow};
         3'(REG_WIN + 1):   byte_out = {7'b0, snap.lose};
         default:           byte_out = 8'h00;
      endcase
   end

endmodule

// File: rtl/ball_packet_tx.sv
// rtl/ball_packet_tx.sv - snapshots ball state and sends it as a 7-byte I2C register write
module ball_packet_tx
   import link_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h42,
   parameter int         MAX_RETRY  = 3,
   parameter int         GAP_CYCLES = 250
) (
   input  logic       clk_25MHZ,
   input  logic       reset,
   input  logic       ball_send_trigger,
   input  logic [9:0] ball_y,
   input  logic [9:0] ball_vy,
   input  logic [1:0] gravity_counter,
   input  logic       speed_slow,
   input  logic       is_lose,
   output logic       is_i2c_master_done,
   output logic       link_error,
   ball_packet_tx_if.master tx
);

   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int GAP_W   = $clog2(GAP_CYCLES);

   tx_state_t          state_q, state_d;
   snap_t              snap_q, snap_d;
   logic [2:0]         idx_q, idx_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               link_error_q, link_error_d;
   // Set once the trigger has been seen low while idle; a new frame needs it
   logic               armed_q, armed_d;

   logic [7:0]         frame_byte;
   logic               in_send;
   logic               last_byte;

   frame_builder u_frame_builder (
      .snap     (snap_q),
      .idx      (idx_q),
      .byte_out (frame_byte)
   );

   assign in_send   = (state_q == SEND);
   assign last_byte = (idx_q == 3'(FRAME_BYTES - 1));

   assign tx.i2c_addr = SLAVE_ADDR;
   assign tx.tx_valid = in_send;
   assign tx.tx_data  = in_send ? frame_byte : 8'h00;
   assign tx.tx_first = in_send && (idx_q == 3'd0);
   assign tx.tx_last  = in_send && last_byte;

   assign is_i2c_master_done = (state_q == DONE);
   assign link_error         = link_error_q;

   // State register; reset clears tx_valid immediately so the master abandons its transfer
   always_ff @(posedge clk_25MHZ or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         snap_q       <= '0;
         idx_q        <= 3'd0;
         retry_q      <= '0;
         gap_q        <= '0;
         link_error_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         idx_q        <= idx_d;
         retry_q      <= retry_d;
         gap_q        <= gap_d;
         link_error_q <= link_error_d;
         armed_q      <= armed_d;
      end
   end

   // Next-state: latch, byte stepping, NACK retry with idle gap, and done handshake
   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      idx_d        = idx_q;
      retry_d      = retry_q;
      gap_d        = gap_q;
      link_error_d = link_error_q;
      armed_d      = armed_q;

      case (state_q)
         IDLE: begin
            if (!ball_send_trigger) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               snap_d.y     = ball_y;
               snap_d.vy    = ball_vy;
               snap_d.grav  = gravity_counter;
               snap_d.slow  = speed_slow;
               snap_d.lose  = is_lose;
               link_error_d = 1'b0;
               retry_d      = '0;
               idx_d        = 3'd0;
               armed_d      = 1'b0;
               state_d      = SEND;
            end
         end

         SEND: begin
            // A NACK outranks a simultaneous ready
            if (tx.tx_nack) begin
               if (int'(retry_q) < MAX_RETRY) begin
                  retry_d = retry_q + 1'b1;
                  gap_d   = '0;
                  state_d = GAP;
               end else begin
                  link_error_d = 1'b1;
                  state_d      = DONE;
               end
            end else if (tx.tx_ready) begin
               if (last_byte) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         GAP: begin
            if (int'(gap_q) == GAP_CYCLES - 1) begin
               idx_d   = 3'd0;
               state_d = SEND;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         DONE: begin
            if (!ball_send_trigger) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/ball_packet_tx.md
Name: ball_packet_tx

Overview:
- Downstream of the game controller on the board-to-board link.
- On `ball_send_trigger`, snapshots the outgoing ball state (or the lose/win notice) and serialises it as a 7-byte register-write frame to the byte-level I2C master.
- Raises `is_i2c_master_done` when the frame completes, and holds it until the controller drops the trigger.
- Frame layout matches the opponent's slave register map: reg0–reg5.

Parameters:
- SLAVE_ADDR, 7'h42, opponent board I2C address, driven on `i2c_addr`.
- MAX_RETRY, 3, full-frame retries after a NACK before abort.
- GAP_CYCLES, 250, idle cycles between a NACK and the retry (10 us at 25 MHz).

Ports:
- clk_25MHZ  in  1  system clock
- reset  in  1  asynchronous, active-high
- ball_send_trigger  in  1  frame request, level, from controller
- ball_y  in  10  ball y position
- ball_vy  in  10  signed y velocity
- gravity_counter  in  2  gravity phase
- speed_slow  in  1  1 = base speed (270000), 0 = fast
- is_lose  in  1  1 = this board lost, send win notice
- is_i2c_master_done  out  1  frame finished, level
- link_error  out  1  frame aborted after retries, sticky per frame
- i2c_addr  out  7  constant SLAVE_ADDR
- tx_valid  out  1  byte offered to I2C master
- tx_data  out  8  byte
- tx_first  out  1  master issues START+address before this byte
- tx_last  out  1  master issues STOP after this byte
- tx_ready  in  1  1-cycle pulse: byte sent and ACKed
- tx_nack  in  1  1-cycle pulse: address or data NACK; master has issued STOP

Behaviour:
- Reset values:
  - state IDLE; all outputs 0 except `i2c_addr`; retry count 0; byte index 0.
  - Reset mid-frame drops `tx_valid` asynchronously; the master aborts its transaction.
- Frame bytes, index 0..6:
  - B0 = 8'h00 (register pointer).
  - B1 = {y[9:8], 6'b0}.
  - B2 = y[7:0].
  - B3 = vy saturated to 8-bit signed: values >127 become 127, values <-128 become -128.
  - B4 = {6'b0, gravity_counter}.
  - B5 = {7'b0, speed_slow}.
  - B6 = {7'b0, is_lose}. The opponent reads bit0 as "you win".
- Snapshot:
  - All inputs are latched into a frame register in the cycle the trigger is seen high in IDLE.
  - Input changes after that cycle do not affect the frame.
- State IDLE:
  - On `ball_send_trigger`=1: latch the snapshot, clear `link_error`, retry=0, index=0, go to SEND.
- State SEND:
  - `tx_valid`=1, `tx_data`=B[index].
  - `tx_first`=(index==0), `tx_last`=(index==6).
  - `tx_valid` first asserts 1 cycle after the latch. Data stays stable until `tx_ready` or `tx_nack`.
  - On `tx_ready`:
    - If index==6: `tx_valid`=0 next cycle, go to DONE.
    - Otherwise: index+1. `tx_valid` stays high with the next byte; back-to-back is allowed.
  - On `tx_nack`: `tx_valid`=0 next cycle.
    - If retry<MAX_RETRY: retry+1, go to GAP.
    - Otherwise: `link_error`=1, go to DONE.
  - If `tx_ready` and `tx_nack` arrive in the same cycle, `tx_nack` wins.
- State GAP:
  - Count GAP_CYCLES cycles, then index=0, go to SEND. The frame restarts from B0 with the same snapshot.
- State DONE:
  - `is_i2c_master_done`=1, registered, first high on the cycle after the last `tx_ready` (or after the abort).
  - When `ball_send_trigger`=0, go to IDLE; done falls on the next edge.
  - Trigger still high in DONE never starts a new frame. A new frame needs the trigger low for at least 1 cycle in IDLE, then high.
- Trigger dropping mid-frame (SEND/GAP) is ignored. The frame completes atomically and DONE then exits immediately.
- Minimum frame latency with zero-wait master: 1 (latch) + 7 (bytes) + 1 (done) = 9 cycles from trigger to done.
- `link_error` holds until the next frame latch.

Decomposition:
- Shared package `link_pkg`:
  - State enum `tx_state_t` (IDLE, SEND, GAP, DONE).
  - Register index constants REG_Y0..REG_WIN (0..5).
  - FRAME_BYTES=7.
  - The `sat10to8` function. The slave-side register decode uses the same package.
- One sub-module, `frame_builder`: combinational byte mux, B[index] from the snapshot, including saturation.
- The FSM, counters and snapshot register stay in `ball_packet_tx`.

Test Plan:
- Single frame: y=10'h2A5, vy=-3, grav=2, slow=1, lose=0, master ACKs every byte immediately.
  - Required response: bytes 00,80,A5,FD,02,01,00; `tx_first` only on B0, `tx_last` only on B6; done high 9 cycles after the trigger edge.
  - Trigger drops 2 cycles after done → done low 1 cycle later.
- Saturation: vy=+200 → B3=7F; vy=-300 → B3=80. Snapshot: change y during SEND → frame still carries the latched y.
- NACK on B3 once: `tx_valid` low, 250 idle cycles, frame resent from B0 with identical bytes; done asserted, `link_error`=0.
- Four consecutive address NACKs: after the 4th NACK, no 5th attempt; `link_error`=1 and done=1; the next trigger clears `link_error`.
- Trigger held high in DONE for 100 cycles → no second frame. Trigger dropped during B2 → frame completes and done pulses 1 cycle.
- Reset asserted during B4 → `tx_valid`, done and `link_error` all 0 immediately, state IDLE; a new trigger after reset sends a fresh frame from B0.
